// File: rtl/rv_config.sv
// ============================================================================
// Package : rv_config
// Brief   : Memory-map constants shared by the instruction-side blocks.
//           TEXT_BEGIN is the byte address of the first text word and the
//           text region spans 2**TEXT_BITS bytes from there.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_config;

    localparam int          TEXT_BITS  = 8;
    localparam logic [31:0] TEXT_BEGIN = 32'h0040_0000;

endpackage

`default_nettype wire

// File: rtl/example_text_fetch.sv
// ============================================================================
// Module  : example_text_fetch
// Brief   : Sequential instruction prefetcher. Reads one word per cycle from a
//           combinational text memory into a DEPTH-entry FIFO and presents the
//           head as a valid/ready stream of {instruction, byte address}.
//           Redirect flushes the FIFO and restarts fetch; misaligned or
//           out-of-region fetch addresses raise a sticky fault.
//           Optional feature macro: EXAMPLE_TEXT_FETCH_PERF_EN adds the
//           fetch_count / stall_count performance counter outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module example_text_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = rv_config::TEXT_BEGIN
) (
    input  logic                             clock,
    input  logic                             reset,
    output logic [rv_config::TEXT_BITS-3:0]  mem_address,
    input  logic [31:0]                      mem_q,
    input  logic                             redirect,
    input  logic [31:0]                      redirect_pc,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      out_inst,
    output logic [31:0]                      out_pc,
    output logic                             fault
`ifdef EXAMPLE_TEXT_FETCH_PERF_EN
    ,
    output logic [31:0]                      fetch_count,
    output logic [31:0]                      stall_count
`endif
);

    localparam int          TEXT_BITS = rv_config::TEXT_BITS;
    localparam int          PTR_W     = $clog2(DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    // One past the last text byte; 33 bits so a region ending at 2**32 is exact.
    localparam logic [32:0] TEXT_END  = {1'b0, rv_config::TEXT_BEGIN} + (33'd1 << TEXT_BITS);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic             fault_q,    fault_d;

    // FIFO payload storage; only meaningful where count says an entry lives.
    logic [31:0]      inst_mem_q [DEPTH];
    logic [31:0]      pc_mem_q   [DEPTH];

    logic             pop;
    logic             push;
    logic             full;
    logic             in_range;
    logic             push_opportunity;

    // ------------------------------------------------------------------------
    // Combinational status
    // ------------------------------------------------------------------------
    assign mem_address = fetch_pc_q[TEXT_BITS-1:2];
    assign out_valid   = (count_q != '0);
    assign out_inst    = inst_mem_q[rd_ptr_q];
    assign out_pc      = pc_mem_q[rd_ptr_q];
    assign fault       = fault_q;

    assign pop      = out_valid && out_ready;
    assign full     = (count_q == FULL_COUNT);
    assign in_range = (fetch_pc_q >= rv_config::TEXT_BEGIN) &&
                      ({1'b0, fetch_pc_q} < TEXT_END);
    // A slot is available when not full, or when the head leaves this cycle.
    assign push_opportunity = !fault_q && (!full || pop);

    // Next-state: redirect flushes and restarts; otherwise pop/push the FIFO.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fault_d    = fault_q;
        push       = 1'b0;

        if (reset) begin
            push = 1'b0;
        end else if (redirect) begin
            // Any concurrent transfer is simply dropped along with the queue.
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fetch_pc_d = redirect_pc;
            fault_d    = (redirect_pc[1:0] != 2'b00);
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_opportunity) begin
                if (in_range) begin
                    push       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end else begin
                    // Ran off the text region (or started outside it): stop.
                    fault_d = 1'b1;
                end
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fault_q    <= fault_d;
        end
    end

    // FIFO tail write of the fetched word and its byte address.
    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= mem_q;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

`ifdef EXAMPLE_TEXT_FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    // Performance counters: cleared only by reset, wrap naturally at 2**32.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (push) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: doc/example_text_fetch.md
EXAMPLE_TEXT_FETCH -- requirements
Module: example_text_fetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default rv_config::TEXT_BEGIN, meaning the first fetch byte address after reset.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 The block SHALL have port mem_address, output, rv_config::TEXT_BITS-2, word address driven to the text memory.
REQ-006 The block SHALL have port mem_q, input, 32, instruction word returned combinationally for mem_address in the same cycle.
REQ-007 The block SHALL have port redirect, input, 1, a flush and restart request.
REQ-008 The block SHALL have port redirect_pc, input, 32, the byte address to restart fetch from.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the FIFO head holds an instruction.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the head.
REQ-011 The block SHALL have port out_inst, output, 32, the head instruction word.
REQ-012 The block SHALL have port out_pc, output, 32, the head byte address.
REQ-013 The block SHALL have port fault, output, 1, a sticky fetch-fault flag.

Function
REQ-014 The block SHALL keep a fetch_pc register; mem_address SHALL be fetch_pc[TEXT_BITS-1:2], driven every cycle.
REQ-015 Push: in a non-reset cycle with no redirect, no fault, and FIFO not full or popping this cycle, the block SHALL write {mem_q, fetch_pc} to the tail and set fetch_pc = fetch_pc + 4.
REQ-016 Pop: a transfer SHALL occur when out_valid and out_ready are both high; the head then advances.
REQ-017 Push and pop in the same cycle SHALL be legal when full and when holding one entry; the count is then unchanged.
REQ-018 out_valid SHALL be high iff count > 0; out_inst and out_pc SHALL come straight from registered FIFO storage, with no combinational path from mem_q.
REQ-019 Latency: an instruction pushed in cycle N SHALL be visible at the outputs in cycle N+1.
REQ-020 Redirect SHALL take priority over push and pop: it flushes the FIFO (count=0), sets fetch_pc=redirect_pc, pushes nothing, and clears fault; a transfer asserted in the same cycle SHALL count as consumed.
REQ-021 A redirect with redirect_pc[1:0] != 0 SHALL set fault next cycle instead of fetching.
REQ-022 If fetch_pc is outside [TEXT_BEGIN, TEXT_BEGIN + 2**TEXT_BITS) at a push opportunity, the block SHALL set fault, push nothing, and leave fetch_pc unchanged; this covers running off the text end.
REQ-023 While fault is set, entries already queued SHALL still drain normally; no new pushes SHALL occur until redirect or reset.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH with no overflow or underflow.

Reset
REQ-025 When reset is high at a clock edge, the block SHALL set fetch_pc=RESET_PC, count=0, pointers=0 and fault=0; out_valid SHALL be 0 in the following cycle.
REQ-026 Reset asserted mid-operation SHALL discard all queued entries and override redirect; the first push SHALL happen in the first cycle with reset low.

Configuration
REQ-027 With EXAMPLE_TEXT_FETCH_PERF_EN defined, the block SHALL add output ports fetch_count[31:0] (number of pushes) and stall_count[31:0] (cycles with out_valid=1 and out_ready=0); both SHALL be zeroed by reset, wrap at 2**32, and be unaffected by redirect.
REQ-028 Without EXAMPLE_TEXT_FETCH_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then out_ready=1 continuously, memory word i = i -> out_valid is first high in cycle 2 after reset release, with out_pc=TEXT_BEGIN and out_inst=0, then one word per cycle, pc +4.
REQ-030 DEPTH=4, out_ready=0 for 10 cycles -> exactly 4 pushes, then mem_address frozen; raise out_ready -> words 0..3 drain in order, then stream continues.
REQ-031 Redirect to TEXT_BEGIN+0x40 with 3 entries queued -> out_valid=0 next cycle, then out_pc=TEXT_BEGIN+0x40 one cycle later.
REQ-032 Redirect to TEXT_BEGIN+0x42 -> fault=1 and out_valid stays 0; redirect to TEXT_BEGIN -> fault=0 and fetch resumes.
REQ-033 Run fetch_pc to the last text word -> that word is delivered, then fault=1 and no further pushes.
REQ-034 With EXAMPLE_TEXT_FETCH_PERF_EN, 8 cycles with out_ready=0 after fill -> stall_count=8 and fetch_count=DEPTH.
